piso_serial_tx: RTL
===================

Name: piso_serial_tx

Overview:
Parallel-in, serial-out transmitter. It accepts WIDTH-bit words over a valid/ready handshake and drives them out one bit per enabled clock on a single serial line, with framing strobes. It is the sending end that feeds the team's serial shift-register and deserializer chains. A one-word holding buffer lets consecutive words stream with no idle bit between them.

Parameters:
WIDTH, 4, bits per word; must be >= 2.
LSB_FIRST, 1, 1 = bit 0 transmitted first (right-shift order); 0 = bit WIDTH-1 first.

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-low reset (0 = reset asserted)
din  input  WIDTH  parallel word to transmit
din_valid  input  1  din holds a word to transfer
din_ready  output  1  block can take a word this cycle
en  input  1  bit strobe; serial output advances only on edges where en=1
so  output  1  serial data out
so_valid  output  1  so carries a frame bit
frame_start  output  1  so carries bit 0 of a word (first bit sent)
done  output  1  last bit of the current word is consumed on this edge

Behaviour:
- Internal state:
  - shift register sh[WIDTH-1:0]
  - bit counter cnt, width $clog2(WIDTH)
  - holding register hold[WIDTH-1:0] with flag hold_full
  - FSM with states IDLE and SHIFT
- Reset (reset=0, async, no clock needed):
  - state=IDLE; sh, hold, cnt = 0; hold_full=0.
  - Outputs so, so_valid, frame_start, done and din_ready are all 0 while reset is low.
  - Reset mid-word aborts the word and discards any held word; no partial bits resume.
- Handshake:
  - din_ready = reset & ~hold_full.
  - A transfer occurs on an edge with din_valid & din_ready; din is written to hold and hold_full is set to 1.
  - din must not be sampled on any other edge.
- IDLE: if hold_full, the next edge does sh<=hold, hold_full<=0, cnt<=0, state<=SHIFT. A transfer into an empty hold and a hold-to-sh move never occur on the same edge.
- SHIFT:
  - Output decode:
    - so = LSB_FIRST ? sh[0] : sh[WIDTH-1].
    - so_valid = 1.
    - frame_start = (cnt==0).
    - done = en & (cnt==WIDTH-1).
  - en=0: sh, cnt and state hold; so stays stable.
  - en=1 and cnt<WIDTH-1: shift (right if LSB_FIRST, else left, with zero fill); cnt<=cnt+1.
  - en=1 and cnt==WIDTH-1:
    - If hold_full: sh<=hold, hold_full<=0, cnt<=0, stay in SHIFT (back-to-back, no gap).
    - Otherwise: state<=IDLE.
- Outside SHIFT: so=0, so_valid=0, frame_start=0, done=0.
- Latency: a word accepted on edge k while IDLE drives its first bit after edge k+1.
- Throughput: one word per WIDTH enabled cycles, sustained. Because WIDTH>=2, hold always drains before the next word needs it.
- Backpressure: while a word is shifting and hold_full=1, din_ready=0 until that held word moves into sh.

Test Plan:
- WIDTH=4, LSB_FIRST=1, en=1: accept din=4'b1011 -> one cycle later so = 1,1,0,1 on 4 consecutive cycles; so_valid high for exactly 4 cycles; frame_start on the 1st bit; done on the 4th bit; then IDLE with so=0.
- LSB_FIRST=0, din=4'b1011 -> so = 1,0,1,1.
- Back-to-back: offer 4'hA then 4'h5 with din_valid held -> so_valid high for 8 contiguous cycles, bits 0,1,0,1,1,0,1,0; frame_start on cycles 0 and 4; done on cycles 3 and 7.
- Stall: during word 4'b1011, drive en=0 for 3 cycles after the 2nd bit -> so holds 1 for those 3 cycles and cnt is frozen; the remaining bits 0,1 follow when en=1 returns; total so_valid = 7 cycles.
- Backpressure: while the 1st word is shifting and a 2nd word is in hold, offer a 3rd word -> din_ready=0 until the hold-to-sh move; the 3rd word is accepted on the next edge and no word is lost or duplicated.
- Async reset: assert reset=0 between edges in the middle of a word, with hold full -> so, so_valid, din_ready drop to 0 immediately; after release, no stale bits appear; a new word 4'b0110 transmits 0,1,1,0 cleanly.

Source files
------------

// File: rtl/piso_serial_tx.sv
// Parallel-in, serial-out transmitter with a one-word holding buffer so that
// consecutive words leave on the serial line with no idle bit between them.
module piso_serial_tx #(
  parameter int WIDTH     = 4,
  parameter int LSB_FIRST = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  input  logic             en,
  output logic             so,
  output logic             so_valid,
  output logic             frame_start,
  output logic             done
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           state_reg;
  logic [WIDTH-1:0] sh_reg;
  logic [WIDTH-1:0] hold_reg;
  logic             hold_full_reg;
  logic [CW-1:0]    cnt_reg;
  logic [WIDTH-1:0] sh_shifted;
  logic             sh_out_bit;
  logic             shifting;
  logic             last_bit;

  // Shift direction and the bit presented on the line are fixed at elaboration.
  generate
    if (LSB_FIRST != 0) begin : g_lsb_first
      assign sh_shifted = {1'b0, sh_reg[WIDTH-1:1]};
      assign sh_out_bit = sh_reg[0];
    end else begin : g_msb_first
      assign sh_shifted = {sh_reg[WIDTH-2:0], 1'b0};
      assign sh_out_bit = sh_reg[WIDTH-1];
    end
  endgenerate

  assign shifting    = (state_reg == SHIFT);
  assign last_bit    = (cnt_reg == LAST);
  assign din_ready   = reset & ~hold_full_reg;
  assign so          = shifting & sh_out_bit;
  assign so_valid    = shifting;
  assign frame_start = shifting & (cnt_reg == '0);
  assign done        = shifting & en & last_bit;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg     <= IDLE;
      sh_reg        <= '0;
      hold_reg      <= '0;
      hold_full_reg <= 1'b0;
      cnt_reg       <= '0;
    end else begin
      // A transfer only happens while hold is empty, so it never collides
      // with the hold-to-shifter moves below.
      if (din_valid && din_ready) begin
        hold_reg      <= din;
        hold_full_reg <= 1'b1;
      end
      case (state_reg)
        IDLE: begin
          if (hold_full_reg) begin
            sh_reg        <= hold_reg;
            hold_full_reg <= 1'b0;
            cnt_reg       <= '0;
            state_reg     <= SHIFT;
          end
        end
        SHIFT: begin
          if (en) begin
            if (last_bit) begin
              if (hold_full_reg) begin
                sh_reg        <= hold_reg;
                hold_full_reg <= 1'b0;
                cnt_reg       <= '0;
              end else begin
                state_reg <= IDLE;
              end
            end else begin
              sh_reg  <= sh_shifted;
              cnt_reg <= cnt_reg + CW'(1);
            end
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule
